alu16: RTL and testbench

- 16-bit registered arithmetic unit for the 8-core matrix-multiplication processor.
- Each core uses one instance for the multiply-accumulate datapath: add, subtract, multiply and pass-through.
- Operands A and B come from the core's data buses; the result drives the C bus together with a registered zero flag.

---
 rtl/alu16.sv | 148 ++++++++++++++
 tb/tb_alu16.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
//  Module      : alu16
//  Description : Registered 16-bit arithmetic unit (ADD / SUB / MUL / PASS)
//                for the multiply-accumulate datapath of one core. The result
//                and the zero flag are registered. There is one cycle of
//                latency and one operation per cycle.
//  Options     : ALU_FLAGS_EN - when defined, adds registered carry/borrow (c),
//                multiply overflow (v) and negative (n) flag outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             enable,
    input  logic [1:0]       ALU_opcode,
    input  logic [WIDTH-1:0] data_A_bus,
    input  logic [WIDTH-1:0] data_B_bus,
`ifdef ALU_FLAGS_EN
    output logic             c,
    output logic             v,
    output logic             n,
`endif
    output logic             z,
    output logic [WIDTH-1:0] data_C_bus
);

    localparam logic [1:0] c_OP_ADD  = 2'd0;
    localparam logic [1:0] c_OP_SUB  = 2'd1;
    localparam logic [1:0] c_OP_MUL  = 2'd2;
    localparam logic [1:0] c_OP_PASS = 2'd3;

    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    logic [WIDTH-1:0] r_c_bus;
    logic             r_z;

    assign w_sub = data_A_bus - data_B_bus;

`ifdef ALU_FLAGS_EN
    // The wide forms are needed only to expose the carry and the upper
    // product half for the flags.
    logic [WIDTH:0]     w_sum_full;
    logic [2*WIDTH-1:0] w_prod_full;
    logic               w_add_carry;
    logic               w_sub_borrow;
    logic               w_mul_ovf;
    logic               w_c_next;
    logic               w_v_next;
    logic               r_c;
    logic               r_v;
    logic               r_n;

    assign w_sum_full   = {1'b0, data_A_bus} + {1'b0, data_B_bus};
    assign w_prod_full  = {{WIDTH{1'b0}}, data_A_bus} * {{WIDTH{1'b0}}, data_B_bus};
    assign w_add        = w_sum_full[WIDTH-1:0];
    assign w_mul        = w_prod_full[WIDTH-1:0];
    assign w_add_carry  = w_sum_full[WIDTH];
    assign w_sub_borrow = (data_A_bus < data_B_bus);
    assign w_mul_ovf    = |w_prod_full[2*WIDTH-1:WIDTH];
`else
    // Only the low WIDTH bits are kept. Carry and the upper product half are
    // dropped by the context width.
    assign w_add = data_A_bus + data_B_bus;
    assign w_mul = data_A_bus * data_B_bus;
`endif

    // Select the next-state result. An unknown opcode falls to zero.
    always_comb begin
        w_result = '0;
`ifdef ALU_FLAGS_EN
        w_c_next = 1'b0;
        w_v_next = 1'b0;
`endif
        case (ALU_opcode)
            c_OP_ADD: begin
                w_result = w_add;
`ifdef ALU_FLAGS_EN
                w_c_next = w_add_carry;
`endif
            end
            c_OP_SUB: begin
                w_result = w_sub;
`ifdef ALU_FLAGS_EN
                w_c_next = w_sub_borrow;
`endif
            end
            c_OP_MUL: begin
                w_result = w_mul;
`ifdef ALU_FLAGS_EN
                w_v_next = w_mul_ovf;
`endif
            end
            c_OP_PASS: begin
                w_result = data_A_bus;
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    // The zero flag is derived from the same value that is loaded into C.
    // This keeps both registers in step.
    assign w_zero = (w_result == '0);

    // Result and zero flag registers. Reset clears them at once, and enable
    // gates every load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_bus <= '0;
            r_z     <= 1'b0;
        end else if (enable) begin
            r_c_bus <= w_result;
            r_z     <= w_zero;
        end
    end

    assign data_C_bus = r_c_bus;
    assign z          = r_z;

`ifdef ALU_FLAGS_EN
    // Status flag registers. They follow the same reset and enable rules as C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else if (enable) begin
            r_c <= w_c_next;
            r_v <= w_v_next;
            r_n <= w_result[WIDTH-1];
        end
    end

    assign c = r_c;
    assign v = r_v;
    assign n = r_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu16
//  Description : Self-checking bench for alu16. It applies table-driven
//                vectors and then hand-written reset, hold and wrap sequences.
//                The flag outputs are checked when ALU_FLAGS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu16;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [1:0]       ALU_opcode;
    logic [WIDTH-1:0] data_A_bus;
    logic [WIDTH-1:0] data_B_bus;
    logic             z;
    logic [WIDTH-1:0] data_C_bus;
`ifdef ALU_FLAGS_EN
    logic             c;
    logic             v;
    logic             n;
`endif

    int n_cmp;
    int n_bad;

    alu16 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ALU_opcode (ALU_opcode),
        .data_A_bus (data_A_bus),
        .data_B_bus (data_B_bus),
`ifdef ALU_FLAGS_EN
        .c          (c),
        .v          (v),
        .n          (n),
`endif
        .z          (z),
        .data_C_bus (data_C_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_c_bus;
        logic        exp_z;
        logic        exp_cf;
        logic        exp_vf;
        logic        exp_nf;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] exp_c_bus, input logic exp_z);
        check({name, ".C"}, {16'd0, data_C_bus}, {16'd0, exp_c_bus});
        check({name, ".z"}, {31'd0, z}, {31'd0, exp_z});
    endtask

`ifdef ALU_FLAGS_EN
    task automatic check_flags(input string name, input logic ec, input logic ev, input logic en);
        check({name, ".c"}, {31'd0, c}, {31'd0, ec});
        check({name, ".v"}, {31'd0, v}, {31'd0, ev});
        check({name, ".n"}, {31'd0, n}, {31'd0, en});
    endtask
`endif

    // Drive the inputs away from the active edge, then sample just after the edge.
    task automatic drive(input logic en_i, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        enable     = en_i;
        ALU_opcode = op;
        data_A_bus = a;
        data_B_bus = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //             op     A       B       C       z     c     v     n
        vecs[0]  = '{2'd0, 16'd6304, 16'd1843, 16'd8147,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 16'd6304, 16'd1843, 16'd4461,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 16'd45,   16'd20,   16'd900,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'd2, 16'd300,  16'd300,  16'd24464, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'd1, 16'd45,   16'd45,   16'd0,     1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 16'd45,   16'd20,   16'd65,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'd1, 16'd0,    16'd1,    16'd65535, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{2'd3, 16'd1234, 16'd999,  16'd1234,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 16'hFFFF, 16'd1,    16'd0,     1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 16'd256,  16'd256,  16'd0,     1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 16'h8000, 16'd1,    16'h8001,  1'b0, 1'b0, 1'b0, 1'b1};

        // Reset and hold: rst is low for 5 cycles while enable is 0.
        rst        = 1'b0;
        enable     = 1'b0;
        ALU_opcode = 2'd0;
        data_A_bus = 16'd6304;
        data_B_bus = 16'd1843;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("reset_hold", 16'd0, 1'b0);
        end
`ifdef ALU_FLAGS_EN
        check_flags("reset_hold", 1'b0, 1'b0, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        check_out("post_reset_en0", 16'd0, 1'b0);

        // Table-driven vectors, one per cycle, back to back.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_c_bus, vecs[i].exp_z);
`ifdef ALU_FLAGS_EN
            check_flags($sformatf("vec%0d", i), vecs[i].exp_cf, vecs[i].exp_vf, vecs[i].exp_nf);
`endif
        end

        // Asynchronous reset between edges clears the outputs with no clock edge.
        drive(1'b1, 2'd0, 16'd6304, 16'd1843);
        step();
        check_out("pre_async", 16'd8147, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 16'd0, 1'b0);
        #1;
        rst = 1'b1;
        step();
        check_out("resume_after_rst", 16'd8147, 1'b0);

        // Wrap to 65535, then hold while enable is low and the inputs churn.
        drive(1'b1, 2'd1, 16'd0, 16'd1);
        step();
        check_out("wrap", 16'd65535, 1'b0);
        drive(1'b0, 2'd2, 16'd7, 16'd9);
        step();
        check_out("hold1", 16'd65535, 1'b0);
        drive(1'b0, 2'd1, 16'd5, 16'd5);
        step();
        check_out("hold2", 16'd65535, 1'b0);
`ifdef ALU_FLAGS_EN
        check_flags("hold2", 1'b1, 1'b0, 1'b1);
`endif
        drive(1'b1, 2'd3, 16'd1234, 16'd0);
        step();
        check_out("pass_after_hold", 16'd1234, 1'b0);

        // Opcode changes on successive edges each produce their own result.
        drive(1'b1, 2'd0, 16'd10, 16'd3);
        step();
        check_out("b2b_add", 16'd13, 1'b0);
        drive(1'b1, 2'd2, 16'd10, 16'd3);
        step();
        check_out("b2b_mul", 16'd30, 1'b0);
        drive(1'b1, 2'd1, 16'd10, 16'd10);
        step();
        check_out("b2b_sub", 16'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
